// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants and state encoding for the cache line refill engine.
package cache_refill_ctrl_pkg;

  localparam int LINE_WORDS = 16;
  localparam int OFFSET_W   = 6;
  localparam int IDX_W      = 4;

  // Fixed AR fields driven by the read merge for every refill burst.
  localparam logic [7:0] ARLEN   = 8'h0f;
  localparam logic [2:0] ARSIZE  = 3'b010;
  localparam logic [1:0] ARBURST = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cache_refill_ctrl_line_buf.sv
// Line assembly buffer: one word written per beat, whole line visible at once.
module refill_line_buf
  import cache_refill_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic [31:0]              data_i,
  output logic [32*LINE_WORDS-1:0] line_o
);

  logic [LINE_WORDS-1:0][31:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= data_i;
  end

  assign line_o = mem_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill engine: one 16-beat burst per miss, streams each beat and
// presents the assembled line for a single cycle.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     miss_valid,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ready,
  output logic                     ren,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     word_valid,
  output logic [IDX_W-1:0]         word_idx,
  output logic [31:0]              word_data,
  output logic                     line_valid,
  output logic [ADDR_W-1:0]        line_addr,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the AR request holds araddr stable until that edge.
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wv_q, wv_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              buf_we;

  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[OFFSET_W-1:0];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wv_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wv_q    <= wv_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wv_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          addr_d  = {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          // A beat past the last slot without rlast is dropped, so the
          // counter never wraps onto word 0 of a partially built line.
          if (cnt_q == LAST_IDX && !rlast) begin
            err_d = 1'b1;
          end else begin
            buf_we  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            wv_d    = 1'b1;
            widx_d  = cnt_q;
            wdata_d = rdata;
          end
          if (rlast) begin
            state_d = S_DONE;
            if (cnt_q != LAST_IDX) err_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  refill_line_buf u_line_buf (
    .clk    (aclk),
    .we_i   (buf_we),
    .idx_i  (cnt_q),
    .data_i (rdata),
    .line_o (line_data)
  );

  assign miss_ready = (state_q == S_IDLE);
  assign ren        = (state_q == S_AR) || (state_q == S_R);
  assign arvalid    = (state_q == S_AR);
  assign araddr     = addr_q;
  assign line_addr  = addr_q;
  assign line_valid = (state_q == S_DONE);
  assign word_valid = wv_q;
  assign word_idx   = widx_q;
  assign word_data  = wdata_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed and randomized refill scenarios checked against a line/beat model.
module tb_cache_refill_ctrl;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         ren;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  rdata = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         word_valid;
  logic [3:0]   word_idx;
  logic [31:0]  word_data;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [511:0] line_data;
  logic         err;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the buffer's contents as the cache would see them and the
  // sticky error flag.
  logic [31:0] exp_line [16];
  logic        exp_err;

  cache_refill_ctrl #(.ADDR_W(32)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .ren        (ren),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .word_data  (word_data),
    .line_valid (line_valid),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [511:0] exp_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = exp_line[i];
    return f;
  endfunction

  // One complete miss: request, AR phase, beats 0..last_at, line hand-off.
  task automatic do_refill(input logic [31:0] addr, input int stall, input int last_at,
                           input bit gaps, input bit fixed_data, input int rst_after,
                           input bit hold_next, input logic [31:0] next_addr);
    logic [31:0] la;
    logic [31:0] d;
    int budget;
    bit acc;
    int idx;
    la = {addr[31:6], 6'b0};
    miss_valid = 1'b1;
    miss_addr  = addr;
    budget = 0;
    while (miss_ready !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    chk("miss_ready_wait", miss_ready, 1'b1);
    tick();
    miss_valid = 1'b0;
    chk("ar_ren", ren, 1'b1);
    chk("ar_arvalid", arvalid, 1'b1);
    chk("ar_araddr", araddr, la);
    chk("ar_miss_ready", miss_ready, 1'b0);
    repeat (stall) begin
      tick();
      chk("stall_arvalid", arvalid, 1'b1);
      chk("stall_araddr", araddr, la);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r_arvalid", arvalid, 1'b0);
    chk("r_ren", ren, 1'b1);
    if (hold_next) begin
      miss_valid = 1'b1;
      miss_addr  = next_addr;
    end
    for (int k = 0; k <= last_at; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("bubble_word_valid", word_valid, 1'b0);
          chk("bubble_line_valid", line_valid, 1'b0);
        end
      end
      d = fixed_data ? 32'h1000 + k : $urandom;
      rvalid = 1'b1;
      rdata  = d;
      rlast  = (k == last_at);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      acc = (k < 15) || (k == last_at);
      idx = (k < 15) ? k : 15;
      if (acc) exp_line[idx] = d;
      chk("word_valid", word_valid, acc);
      if (acc) begin
        chk("word_idx", word_idx, idx);
        chk("word_data", word_data, d);
      end
      chk("busy_miss_ready", miss_ready, 1'b0);
      if (k == rst_after) begin
        aresetn    = 1'b0;
        miss_valid = 1'b0;
        tick();
        aresetn = 1'b1;
        exp_err = 1'b0;
        chk("rst_ren", ren, 1'b0);
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_line_valid", line_valid, 1'b0);
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        repeat (3) begin
          tick();
          chk("rst_no_line", line_valid, 1'b0);
        end
        return;
      end
      if (k != last_at) chk("early_line_valid", line_valid, 1'b0);
    end
    if (last_at != 15) exp_err = 1'b1;
    chk("line_valid", line_valid, 1'b1);
    chk("line_addr", line_addr, la);
    chk("line_data", line_data, exp_flat());
    chk("err", err, exp_err);
    chk("done_ren", ren, 1'b0);
    tick();
    chk("line_pulse_end", line_valid, 1'b0);
    chk("idle_miss_ready", miss_ready, 1'b1);
    chk("idle_arvalid", arvalid, 1'b0);
  endtask

  initial begin
    exp_err = 1'b0;
    aresetn = 1'b0;
    repeat (2) tick();
    chk("reset_ren", ren, 1'b0);
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_word_valid", word_valid, 1'b0);
    chk("reset_line_valid", line_valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_araddr", araddr, 32'h0);
    chk("reset_line_addr", line_addr, 32'h0);
    chk("reset_word_idx", word_idx, 4'h0);
    chk("reset_miss_ready", miss_ready, 1'b1);
    aresetn = 1'b1;
    tick();

    // Basic refill with immediate AR handshake and back-to-back beats.
    do_refill(32'hBFC0_0124, 0, 15, 1'b0, 1'b1, -1, 1'b0, 32'h0);
    // AR stall of five cycles.
    do_refill($urandom, 5, 15, 1'b0, 1'b0, -1, 1'b0, 32'h0);
    // Gapped beats.
    do_refill($urandom, $urandom_range(0, 3), 15, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    do_refill($urandom, $urandom_range(0, 3), 15, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    // Early rlast on beat 7, then a 17-beat burst.
    do_refill($urandom, 0, 7, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    do_refill($urandom, 1, 16, 1'b0, 1'b0, -1, 1'b0, 32'h0);
    // Reset after beat 4, then a clean refill of 0x40.
    do_refill($urandom, 0, 15, 1'b0, 1'b0, 4, 1'b0, 32'h0);
    do_refill(32'h0000_0040, 0, 15, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    // Second miss held during the burst.
    do_refill($urandom, 2, 15, 1'b1, 1'b0, -1, 1'b1, 32'h2000_0000);
    do_refill(32'h2000_0000, 0, 15, 1'b0, 1'b0, -1, 1'b0, 32'h0);
    // Random refills.
    for (int n = 0; n < 4; n++) begin
      do_refill($urandom, $urandom_range(0, 4), 15, 1'b1, 1'b0, -1, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Per-requestor cache-miss refill engine; one instance each for the I-cache and the D-cache.
- Accepts a line-miss request and drives the read-merge port of that requestor (ren / araddr / arvalid, returned rdata / rlast / rvalid).
- Issues one 16-beat INCR burst, assembles the 64-byte line and hands it to the cache for tag/data write.
- Also streams each beat as it arrives, so the pipeline can take the critical word early.

Parameters:
- LINE_WORDS, 16: words per line. Must match the fixed burst length of the read merge (arlen = 0x0f).
- OFFSET_W, 6: byte-offset bits per line, log2(LINE_WORDS*4).
- ADDR_W, 32: address width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- miss_valid  in  1  miss request from cache
- miss_addr  in  ADDR_W  missing byte address
- miss_ready  out  1  high only in IDLE; request accepted when miss_valid & miss_ready
- ren  out  1  owns the merge read path; drives the merge's inst_ren or data_ren
- araddr  out  ADDR_W  line-aligned burst address
- arvalid  out  1  AR valid
- arready  in  1  AR ready, already gated by ren in the merge
- rdata  in  32  beat data
- rlast  in  1  last beat
- rvalid  in  1  beat valid, already gated by ren in the merge
- word_valid  out  1  one-cycle pulse per accepted beat
- word_idx  out  4  word index of that beat within the line
- word_data  out  32  data of that beat
- line_valid  out  1  one-cycle pulse when the line is complete
- line_addr  out  ADDR_W  line-aligned address of the completed line
- line_data  out  32*LINE_WORDS  word i at bits [32i+31:32i]
- err  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- One clock, aclk. Reset is synchronous and active-low (aresetn).
- Reset values:
  - state = IDLE; ren, arvalid, word_valid, line_valid, err = 0.
  - araddr, line_addr, word_idx = 0; beat counter = 0.
  - line buffer contents: don't-care. line_data is only meaningful while line_valid = 1.
- States: IDLE, AR, R, DONE.
- IDLE:
  - miss_ready = 1.
  - On miss_valid, latch {miss_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0} into araddr/line_addr, clear the counter, go to AR.
  - ren and arvalid go to 1 on the next cycle.
- AR:
  - ren = 1, arvalid = 1, araddr stable.
  - On arready, go to R; arvalid is 0 from the next cycle.
  - An AR handshake may complete in the first AR cycle.
- R:
  - ren = 1, arvalid = 0.
  - Each cycle with rvalid: write rdata into buffer[cnt] and increment cnt (4-bit, wraps).
  - Next cycle after each beat: word_valid = 1, word_idx = cnt_old, word_data = rdata. Latency is one cycle.
  - On rvalid & rlast: go to DONE.
  - If cnt_old != LINE_WORDS-1 at rlast, set err.
  - If a beat arrives with cnt_old = LINE_WORDS-1 and rlast = 0, set err, drop the overflow data and stay in R until rlast.
- DONE (one cycle):
  - line_valid = 1 with the full line; ren = 0; go to IDLE.
  - miss_ready rises the cycle after line_valid, so back-to-back misses have a 1-cycle gap.
- rvalid while not in R: ignored, no state change (the merge gates it by ren anyway).
- miss_valid while not in IDLE: ignored. The requester must hold it.
- Reset mid-burst: returns to IDLE immediately. Remaining beats are discarded because ren = 0 gates them in the merge. No line_valid is produced.
- rready is owned by the merge (constant 1). This block never back-pressures.
- Ownership arbitration between the instance pair is outside this block. Two instances must not both hold ren = 1; the top level serialises via miss_valid.

Decomposition:
- Shared package/header:
  - state encoding (IDLE = 2'd0, AR = 2'd1, R = 2'd2, DONE = 2'd3)
  - LINE_WORDS / OFFSET_W constants
  - AXI fixed-field constants used by the merge (ARLEN = 8'h0f, ARSIZE = 3'b010, ARBURST = 2'b01)
- One sub-module: refill_line_buf. 16x32 register array with a write port (en, idx, data) and a flattened 512-bit read-out. No reset on data.

Test Plan:
1. Basic refill: miss_addr = 0xBFC0_0124, arready on the first AR cycle, 16 beats 0x1000+i back-to-back with rlast on beat 15.
   Expected: araddr = 0xBFC0_0100; 16 word_valid pulses with idx 0..15; line_valid once with word i = 0x1000+i; err = 0.
2. AR stall: arready held low 5 cycles.
   Expected: arvalid = 1 and araddr stable for all 5 cycles; exactly one handshake; then a normal refill.
3. Gapped beats: rvalid with random bubbles, e.g. pattern 1,0,0,1,...
   Expected: word_idx stays contiguous 0..15; line_data is correct; line_valid is exactly 1 cycle after rlast.
4. Protocol errors:
   - rlast on beat 7 → err = 1, line_valid still pulses.
   - 17 beats with rlast on the 17th → err = 1 and word 0 is not overwritten.
5. Reset mid-burst: aresetn low for 1 cycle after beat 4.
   Expected: next cycle ren = 0, miss_ready = 1, no line_valid; a subsequent miss to 0x0000_0040 refills correctly.
6. Busy request: second miss_valid (addr 0x2000_0000) held during refill R.
   Expected: not accepted until miss_ready rises 1 cycle after line_valid; second burst araddr = 0x2000_0000.
